// File: rtl/rv32im_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv32im_bus_arbiter
// Purpose  : Two-master (fetch, load/store) to one-slave Wishbone arbiter.
//            It has a registered grant and a bus-timeout watchdog.
//            Define RV32IM_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module rv32im_bus_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [XLEN-3:0] m0_adr_i,
    input  logic            m0_stb_i,
    output logic [XLEN-1:0] m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic [XLEN-3:0] m1_adr_i,
    input  logic [XLEN-1:0] m1_dat_i,
    input  logic            m1_we_i,
    input  logic [3:0]      m1_sel_i,
    input  logic            m1_stb_i,
    output logic [XLEN-1:0] m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [XLEN-3:0] s_adr_o,
    output logic [XLEN-1:0] s_dat_o,
    output logic            s_we_o,
    output logic [3:0]      s_sel_o,
    output logic            s_stb_o,
    input  logic [XLEN-1:0] s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    output logic [1:0]      grant_o
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_OWN_M0  = 2'd1;
    localparam logic [1:0] c_OWN_M1  = 2'd2;
    localparam logic [1:0] c_RELEASE = 2'd3;

    localparam int              c_TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_TW-1:0] c_TLAST = c_TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [c_TW-1:0] c_TMAX  = c_TW'(TIMEOUT);

    logic [1:0]      r_state;
    logic [c_TW-1:0] r_timer;
    logic            w_own0;
    logic            w_own1;
    logic            w_owned;
    logic            w_stb;
    logic            w_timeout;
    logic            w_pick_m1;

    assign w_own0  = (r_state == c_OWN_M0);
    assign w_own1  = (r_state == c_OWN_M1);
    assign w_owned = w_own0 | w_own1;
    assign w_stb   = (w_own0 & m0_stb_i) | (w_own1 & m1_stb_i);

    // A real ack/err on the last allowed cycle wins over the forced error.
    generate
        if (TIMEOUT > 0) begin : g_wdog
            assign w_timeout = w_owned && (r_timer == c_TLAST) && !s_ack_i && !s_err_i;
        end else begin : g_no_wdog
            assign w_timeout = 1'b0;
        end
    endgenerate

`ifdef RV32IM_ARB_ROUND_ROBIN_EN
    logic r_last_m1;

    assign w_pick_m1 = m1_stb_i && (!m0_stb_i || !r_last_m1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_last_m1 <= 1'b0;
        end else if ((r_state == c_IDLE) && (m0_stb_i || m1_stb_i)) begin
            r_last_m1 <= w_pick_m1;
        end
    end
`else
    assign w_pick_m1 = m1_stb_i;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= c_IDLE;
            r_timer <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_timer <= '0;
                    if (w_pick_m1) begin
                        r_state <= c_OWN_M1;
                    end else if (m0_stb_i) begin
                        r_state <= c_OWN_M0;
                    end
                end
                c_OWN_M0, c_OWN_M1: begin
                    if (!w_stb || s_ack_i || s_err_i || w_timeout) begin
                        r_state <= c_RELEASE;
                    end else if (r_timer != c_TMAX) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // The fetch port is read-only: full-word reads, no write data.
    assign s_stb_o  = w_stb;
    assign s_adr_o  = w_own0 ? m0_adr_i : (w_own1 ? m1_adr_i : '0);
    assign s_we_o   = w_own1 & m1_we_i;
    assign s_sel_o  = w_own0 ? 4'hF : (w_own1 ? m1_sel_i : 4'h0);
    assign s_dat_o  = w_own1 ? m1_dat_i : '0;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = w_own0 & s_ack_i;
    assign m0_err_o = w_own0 & (s_err_i | w_timeout);
    assign m1_ack_o = w_own1 & s_ack_i;
    assign m1_err_o = w_own1 & (s_err_i | w_timeout);
    assign grant_o  = {w_own1, w_own0};

endmodule
`default_nettype wire

// File: tb/tb_rv32im_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32im_bus_arbiter
// Purpose  : Directed and random test of rv32im_bus_arbiter.
//            Outputs are compared against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32im_bus_arbiter;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 4;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [XLEN-3:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic            m0_stb_i, m1_stb_i, m1_we_i;
    logic [3:0]      m1_sel_i, s_sel_o;
    logic [XLEN-1:0] m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic            m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic            s_we_o, s_stb_o, s_ack_i, s_err_i;
    logic [1:0]      grant_o;

    always #5 clk_i = ~clk_i;

    rv32im_bus_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) u_dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .m0_adr_i(m0_adr_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o)
    );

    int n_asrt = 0;
    int n_fail = 0;

    // Reference: who owns the bus (0 none, 1 m0, 2 m1, 3 dead cycle),
    // how long the owner has waited, and who was granted last.
    int own  = 0;
    int age  = 0;
    int last = 1;

    // Slave behaviour: respond after slv_lat strobed cycles (-1 never);
    // mode 0 ack, 1 err, 2 both. spur drives stray acks when unstrobed.
    int slv_lat  = 0;
    int slv_mode = 0;
    int scnt     = 0;
    bit spur     = 1'b0;

    bit         done0, done1;
    logic       obs_ack0, obs_err1;
    logic [1:0] obs_grant;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_grant"}, grant_o, 2'b00);
        chk({tag, "_s_stb"}, s_stb_o, 1'b0);
        chk({tag, "_s_adr"}, s_adr_o, 0);
        chk({tag, "_s_we"},  s_we_o, 1'b0);
        chk({tag, "_s_sel"}, s_sel_o, 4'h0);
        chk({tag, "_s_dat"}, s_dat_o, 0);
        chk({tag, "_acks"},  {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'h0);
        chk({tag, "_mdat"},  {m0_dat_o, m1_dat_o}, {s_dat_i, s_dat_i});
    endtask

    // One clock cycle: drive the slave, check every output, advance model.
    task automatic tick();
        bit owned, ostb, tmo, resp;
        owned   = (own == 1) || (own == 2);
        ostb    = (own == 1) ? m0_stb_i : ((own == 2) ? m1_stb_i : 1'b0);
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_dat_i = $urandom;
        if (owned && ostb && (slv_lat >= 0) && (scnt == slv_lat)) begin
            s_ack_i = (slv_mode != 1);
            s_err_i = (slv_mode != 0);
        end else if (!ostb && spur) begin
            s_ack_i = 1'b1;
        end
        tmo  = owned && (age == TIMEOUT - 1) && !s_ack_i && !s_err_i;
        resp = s_ack_i || s_err_i || tmo;
        #1;
        obs_grant = grant_o;
        obs_ack0  = m0_ack_o;
        obs_err1  = m1_err_o;
        chk("grant", grant_o, (own == 1) ? 2'b01 : ((own == 2) ? 2'b10 : 2'b00));
        chk("s_stb", s_stb_o, ostb);
        chk("s_adr", s_adr_o, (own == 1) ? m0_adr_i : ((own == 2) ? m1_adr_i : 30'h0));
        chk("s_we",  s_we_o, (own == 2) && m1_we_i);
        chk("s_sel", s_sel_o, (own == 1) ? 4'hF : ((own == 2) ? m1_sel_i : 4'h0));
        chk("s_dat", s_dat_o, (own == 2) ? m1_dat_i : 32'h0);
        chk("m0_ack", m0_ack_o, (own == 1) && s_ack_i);
        chk("m0_err", m0_err_o, (own == 1) && (s_err_i || tmo));
        chk("m1_ack", m1_ack_o, (own == 2) && s_ack_i);
        chk("m1_err", m1_err_o, (own == 2) && (s_err_i || tmo));
        chk("m0_dat", m0_dat_o, s_dat_i);
        chk("m1_dat", m1_dat_o, s_dat_i);
        done0 = (own == 1) && resp;
        done1 = (own == 2) && resp;
        if (owned && ostb && !resp) scnt++;
        else scnt = 0;
        case (own)
            0: begin
                if (m0_stb_i && m1_stb_i) begin
`ifdef RV32IM_ARB_ROUND_ROBIN_EN
                    own = (last == 2) ? 1 : 2;
`else
                    own = 2;
`endif
                end else if (m1_stb_i) begin
                    own = 2;
                end else if (m0_stb_i) begin
                    own = 1;
                end
                if (own != 0) last = own;
                age = 0;
            end
            1, 2: begin
                if (!ostb || resp) own = 3;
                else age++;
            end
            default: own = 0;
        endcase
        @(posedge clk_i);
        #1;
    endtask

    // Masters drop their strobe once served; bounded by cycle budget.
    task automatic run(input string tag, input int bound);
        for (int k = 0; k < bound && (m0_stb_i || m1_stb_i); k++) begin
            tick();
            if (done0) m0_stb_i = 1'b0;
            if (done1) m1_stb_i = 1'b0;
        end
        chk({tag, "_served"}, {m0_stb_i, m1_stb_i}, 2'b00);
    endtask

    initial begin
        int         seen;
        logic [1:0] first;
        reset_i  = 1'b1;
        m0_adr_i = '0; m0_stb_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 1'b0; m1_sel_i = 4'h0; m1_stb_i = 1'b0;
        s_dat_i  = 32'h1234_5678; s_ack_i = 1'b0; s_err_i = 1'b0;
        #2;
        chk_idle_outputs("reset");
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        // Single fetch, slave acks 3 cycles after strobe.
        m0_adr_i = 30'h100; m0_stb_i = 1'b1; slv_lat = 3; slv_mode = 0;
        seen = -1;
        for (int k = 0; k < 12 && m0_stb_i; k++) begin
            tick();
            if (obs_ack0 && seen < 0) seen = k;
            if (done0) m0_stb_i = 1'b0;
        end
        chk("fetch_ack_cycle", seen, 4);
        tick();
        tick();

        // Simultaneous requests; m1 writes.
        m0_adr_i = 30'h200; m0_stb_i = 1'b1;
        m1_adr_i = 30'h040; m1_dat_i = 32'hDEAD_BEEF; m1_we_i = 1'b1; m1_sel_i = 4'b0011;
        m1_stb_i = 1'b1; slv_lat = 1;
        first = 2'b00;
        for (int k = 0; k < 20 && (m0_stb_i || m1_stb_i); k++) begin
            tick();
            if (first == 2'b00) first = obs_grant;
            if (done0) m0_stb_i = 1'b0;
            if (done1) m1_stb_i = 1'b0;
        end
        chk("both_first_grant", first, 2'b10);
        chk("both_served", {m0_stb_i, m1_stb_i}, 2'b00);
        tick();
        tick();

        // Watchdog: m1 read never acked, m0 waiting behind it.
        m1_we_i = 1'b0; m1_sel_i = 4'hF; m1_adr_i = 30'h3ff; m1_stb_i = 1'b1; slv_lat = -1;
        tick();
        m0_adr_i = 30'h104; m0_stb_i = 1'b1;
        seen = -1;
        for (int k = 1; k < 10 && m1_stb_i; k++) begin
            tick();
            if (obs_err1 && seen < 0) seen = k;
            if (done1) m1_stb_i = 1'b0;
        end
        chk("timeout_err_cycle", seen, 4);
        slv_lat = 0;
        run("timeout_m0", 10);
        tick();
        tick();

        // Spurious acks while idle.
        spur = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        spur = 1'b0;

        // Asynchronous reset in the middle of an owned fetch.
        m0_adr_i = 30'h180; m0_stb_i = 1'b1; slv_lat = -1;
        tick();
        tick();
        s_ack_i = 1'b1;
        #2;
        reset_i = 1'b1;
        #1;
        chk("rst_async_stb", s_stb_o, 1'b0);
        chk("rst_async_grant", grant_o, 2'b00);
        chk("rst_async_ack", {m0_ack_o, m1_ack_o}, 2'b00);
        own = 0; age = 0; last = 1; scnt = 0;
        m0_stb_i = 1'b0;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        s_ack_i = 1'b0;
        m1_adr_i = 30'h055; m1_stb_i = 1'b1; slv_lat = 0;
        tick();
        tick();
        chk("post_rst_grant", obs_grant, 2'b10);
        run("post_rst", 6);
        tick();
        tick();

        // m0 requesting continuously, m1 every other cycle.
        m0_stb_i = 1'b1; slv_lat = 0;
        for (int k = 0; k < 40; k++) begin
            if (!m1_stb_i && (k % 2 == 0)) begin
                m1_stb_i = 1'b1;
                m1_adr_i = 30'($urandom);
            end
            tick();
            chk("one_hot_grant", obs_grant[0] & obs_grant[1], 1'b0);
            if (done1) m1_stb_i = 1'b0;
            if (done0) m0_adr_i = 30'($urandom);
        end
        run("interleave_tail", 20);
        tick();
        tick();

        // Random traffic with random slave latency and response kind.
        for (int k = 0; k < 400; k++) begin
            if (!m0_stb_i && $urandom_range(0, 2) == 0) begin
                m0_stb_i = 1'b1;
                m0_adr_i = 30'($urandom);
            end
            if (!m1_stb_i && $urandom_range(0, 2) == 0) begin
                m1_stb_i = 1'b1;
                m1_adr_i = 30'($urandom);
                m1_dat_i = $urandom;
                m1_we_i  = 1'($urandom);
                m1_sel_i = 4'($urandom);
            end
            if (own == 0 || own == 3) begin
                slv_lat  = $urandom_range(0, 5);
                slv_mode = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            end
            spur = ($urandom_range(0, 4) == 0);
            tick();
            if (done0) begin
                m0_stb_i = 1'($urandom);
                m0_adr_i = 30'($urandom);
            end
            if (done1) begin
                m1_stb_i = 1'($urandom);
                m1_adr_i = 30'($urandom);
            end
        end
        spur = 1'b0; slv_lat = 0; slv_mode = 0;
        run("random_drain", 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
